// File: rtl/seg7_pkg.sv
// Shared constants for the 3-digit scanned seven-segment display:
// segment patterns, digit count and the control FSM state type.
package seg7_pkg;

  localparam int NUM_DIGITS = 3;

  // Segment order is {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd8_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD nibbles,
// one iteration per clock, eight iterations after a start pulse.
module bin2bcd8_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);
  import seg7_pkg::*;

  logic        run_q, run_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] adj;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                       : bcd_q[4*gi +: 4];
  end

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = 3'd0;
      bin_d = bin;
      bcd_d = 12'd0;
    end else if (run_q) begin
      // Hundreds never exceeds 2 before the final shift, so adj[11] is always 0
      bcd_d = {adj[10:0], bin_q[7]};
      bin_d = {bin_q[6:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= 3'd0;
      bin_q <= 8'd0;
      bcd_q <= 12'd0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  // High during the cycle whose closing edge performs the last iteration
  assign done     = run_q && (cnt_q == 3'd7);
  assign hundreds = bcd_q[11:8];
  assign tens     = bcd_q[7:4];
  assign units    = bcd_q[3:0];

endmodule

// File: rtl/seg7_scan_display.sv
// Loads an 8-bit value, converts it to decimal, and time-multiplexes the
// three digits onto a common seven-segment bus with optional zero blanking.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [2:0] an
);
  import seg7_pkg::*;

  localparam int             PW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(REFRESH_DIV - 1);

  state_t                          state_q;
  logic                            busy_q;
  logic [NUM_DIGITS-1:0][3:0]      dig_q;
  logic                            start;
  logic                            bcd_done;
  logic [3:0]                      bcd_h, bcd_t, bcd_u;

  logic [PW-1:0]                   pre_q, pre_d;
  logic [1:0]                      idx_q, idx_d;
  logic [2:0]                      an_q, an_d;
  logic [6:0]                      seg_q, seg_d;
  logic [NUM_DIGITS-1:0]           blank;
  logic [NUM_DIGITS-1:0][6:0]      dig_seg;

  assign start = (state_q == ST_IDLE) && load;

  bin2bcd8_seq u_bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (value),
    .done     (bcd_done),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .units    (bcd_u)
  );

  // Display digits change only on the DONE edge, so partial results stay hidden
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      dig_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bcd_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          dig_q   <= {bcd_h, bcd_t, bcd_u};
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign blank[0] = 1'b0;
  assign blank[1] = (BLANK_LZ != 0) && (dig_q[2] == 4'd0) && (dig_q[1] == 4'd0);
  assign blank[2] = (BLANK_LZ != 0) && (dig_q[2] == 4'd0);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    assign dig_seg[gi] = blank[gi] ? SEG_BLANK : seg_decode(dig_q[gi]);
  end

  always_comb begin
    pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
    idx_d = idx_q;
    if (idx_q > 2'd2) begin
      idx_d = 2'd0;
    end else if (pre_q == PRE_MAX) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
    // an and seg follow the next index so both switch on the wrap edge
    an_d = 3'b111;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == 2'(i)) an_d[i] = 1'b0;
    end
    case (idx_d)
      2'd1:    seg_d = dig_seg[1];
      2'd2:    seg_d = dig_seg[2];
      default: seg_d = dig_seg[0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 3'b110;
      seg_q <= SEG_0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: scan timing, conversion latency,
// blanking, ignored loads, mid-conversion reset and a full value sweep.
module tb_seg7_scan_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] value = 8'd0;
  logic       busy, busy_nb;
  logic [6:0] seg, seg_nb;
  logic [2:0] an, an_nb;

  int checks = 0;
  int failures = 0;
  logic [6:0] segtab [10];

  seg7_scan_display #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .seg(seg), .an(an)
  );

  seg7_scan_display #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy_nb), .seg(seg_nb), .an(an_nb)
  );

  always #5 clk = ~clk;

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 30 && timed_out; i++) begin
      @(negedge clk);
      if (busy === 1'b0) timed_out = 1'b0;
    end
  endtask

  // Records the segment pattern seen in each digit slot over one full scan
  task automatic capture(output logic [6:0] h, t, u, hn, tn, un);
    h = 'x; t = 'x; u = 'x; hn = 'x; tn = 'x; un = 'x;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      case (an)
        3'b110: u = seg;
        3'b101: t = seg;
        3'b011: h = seg;
        default: ;
      endcase
      case (an_nb)
        3'b110: un = seg_nb;
        3'b101: tn = seg_nb;
        3'b011: hn = seg_nb;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || an !== 3'b110 || seg !== 7'h3F) begin
      failures++;
      $display("FAIL reset_hold busy=%b an=%b seg=%h required busy=0 an=110 seg=3F", busy, an, seg);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      case (k / 4)
        0: begin exp_an = 3'b110; exp_seg = 7'h3F; end
        1: begin exp_an = 3'b101; exp_seg = 7'h00; end
        default: begin exp_an = 3'b011; exp_seg = 7'h00; end
      endcase
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        failures++;
        $display("FAIL reset_scan k=%0d an=%b seg=%h required an=%b seg=%h", k, an, seg, exp_an, exp_seg);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_207;
    logic [6:0] h, t, u, hn, tn, un;
    bit to;
    do_load(8'd207);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_207 cycle=%0d busy=%b required 1", c, busy);
      end
      checks++;
      if (seg !== ((an == 3'b110) ? 7'h3F : 7'h00)) begin
        failures++;
        $display("FAIL hold_207 cycle=%0d an=%b seg=%h required old display", c, an, seg);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_end_207 busy=%b required 0", busy);
    end
    wait_idle(to);
    capture(h, t, u, hn, tn, un);
    checks++;
    if (h !== 7'h5B || t !== 7'h3F || u !== 7'h07) begin
      failures++;
      $display("FAIL digits_207 got %h %h %h required 5B 3F 07", h, t, u);
    end
    $display("test_207 h=%h t=%h u=%h", h, t, u);
  endtask

  task automatic test_blank;
    logic [6:0] h, t, u, hn, tn, un;
    bit to;
    do_load(8'd5);
    wait_idle(to);
    checks++;
    if (to || busy_nb !== 1'b0) begin
      failures++;
      $display("FAIL idle_5 timeout=%0d busy_nb=%b required 0 0", to, busy_nb);
    end
    capture(h, t, u, hn, tn, un);
    checks++;
    if (h !== 7'h00 || t !== 7'h00 || u !== 7'h6D) begin
      failures++;
      $display("FAIL blank_5 got %h %h %h required 00 00 6D", h, t, u);
    end
    checks++;
    if (hn !== 7'h3F || tn !== 7'h3F || un !== 7'h6D) begin
      failures++;
      $display("FAIL noblank_5 got %h %h %h required 3F 3F 6D", hn, tn, un);
    end
    $display("test_blank lz=%h %h %h nolz=%h %h %h", h, t, u, hn, tn, un);
  endtask

  task automatic test_back_to_back;
    logic [6:0] h, t, u, hn, tn, un;
    bit to;
    do_load(8'd255);
    repeat (2) @(posedge clk);
    @(negedge clk);
    value = 8'd9;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    wait_idle(to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL idle_255 busy never fell");
    end
    capture(h, t, u, hn, tn, un);
    checks++;
    if (h !== 7'h5B || t !== 7'h6D || u !== 7'h6D) begin
      failures++;
      $display("FAIL b2b_255 got %h %h %h required 5B 6D 6D", h, t, u);
    end
    $display("test_back_to_back h=%h t=%h u=%h", h, t, u);
  endtask

  task automatic test_reset_mid;
    logic [6:0] h, t, u, hn, tn, un;
    bit to;
    do_load(8'd128);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || an !== 3'b110 || seg !== 7'h3F) begin
      failures++;
      $display("FAIL rst_mid busy=%b an=%b seg=%h required 0 110 3F", busy, an, seg);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    capture(h, t, u, hn, tn, un);
    checks++;
    if (h !== 7'h00 || t !== 7'h00 || u !== 7'h3F) begin
      failures++;
      $display("FAIL rst_mid_disp got %h %h %h required 00 00 3F", h, t, u);
    end
    do_load(8'd128);
    wait_idle(to);
    capture(h, t, u, hn, tn, un);
    checks++;
    if (to || h !== 7'h06 || t !== 7'h5B || u !== 7'h7F) begin
      failures++;
      $display("FAIL reload_128 timeout=%0d got %h %h %h required 06 5B 7F", to, h, t, u);
    end
    $display("test_reset_mid h=%h t=%h u=%h", h, t, u);
  endtask

  task automatic test_sweep;
    logic [6:0] h, t, u, hn, tn, un;
    logic [6:0] eh, et, eu;
    int dh, dt, du;
    bit to;
    int bad;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      do_load(8'(v));
      wait_idle(to);
      capture(h, t, u, hn, tn, un);
      dh = v / 100;
      dt = (v / 10) % 10;
      du = v % 10;
      eh = (dh == 0) ? 7'h00 : segtab[dh];
      et = (dh == 0 && dt == 0) ? 7'h00 : segtab[dt];
      eu = segtab[du];
      checks++;
      if (to || h !== eh || t !== et || u !== eu || hn !== segtab[dh] || tn !== segtab[dt]) begin
        failures++;
        bad++;
        $display("FAIL sweep v=%0d got %h %h %h nolz %h %h required %h %h %h nolz %h %h",
                 v, h, t, u, hn, tn, eh, et, eu, segtab[dh], segtab[dt]);
      end
    end
    $display("test_sweep values=256 bad=%0d", bad);
  endtask

  initial begin
    segtab[0] = 7'h3F; segtab[1] = 7'h06; segtab[2] = 7'h5B; segtab[3] = 7'h4F;
    segtab[4] = 7'h66; segtab[5] = 7'h6D; segtab[6] = 7'h7D; segtab[7] = 7'h07;
    segtab[8] = 7'h7F; segtab[9] = 7'h6F;
    test_reset;
    test_207;
    test_blank;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
